// File: rtl/serving_wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin or fixed-priority ownership of one slave bus.
// Optional slave-ack timeout is compiled in with macro ARB_TIMEOUT_EN.
module serving_wb_arbiter #(
  parameter int RR      = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_m0_adr,
  input  logic [31:0] i_wb_m0_dat,
  input  logic [3:0]  i_wb_m0_sel,
  input  logic        i_wb_m0_we,
  input  logic        i_wb_m0_stb,
  output logic [31:0] o_wb_m0_rdt,
  output logic        o_wb_m0_ack,
  input  logic [31:0] i_wb_m1_adr,
  input  logic [31:0] i_wb_m1_dat,
  input  logic [3:0]  i_wb_m1_sel,
  input  logic        i_wb_m1_we,
  input  logic        i_wb_m1_stb,
  output logic [31:0] o_wb_m1_rdt,
  output logic        o_wb_m1_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("serving_wb_arbiter: TIMEOUT must be at least 1");
  end

  state_e state_q, state_d;
  logic   last_q,  last_d;   // 0 = m0 was granted last, 1 = m1
  logic   own0, own1;
  logic   owner_stb;
  logic   to_hit;

  assign own0      = (state_q == OWN0);
  assign own1      = (state_q == OWN1);
  assign owner_stb = (own0 & i_wb_m0_stb) | (own1 & i_wb_m1_stb);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Counter idles at zero so it is already cleared on entry to an OWN state.
  assign to_hit = owner_stb & ~i_wb_ack & (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!i_wb_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (to_hit) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_wb_m0_stb && i_wb_m1_stb) begin
          state_d = ((RR != 0) && !last_q) ? OWN1 : OWN0;
        end else if (i_wb_m0_stb) begin
          state_d = OWN0;
        end else if (i_wb_m1_stb) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (i_wb_ack || to_hit) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (!i_wb_m0_stb) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (i_wb_ack || to_hit) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (!i_wb_m1_stb) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    o_wb_adr    = '0;
    o_wb_dat    = '0;
    o_wb_sel    = '0;
    o_wb_we     = 1'b0;
    o_wb_m0_ack = 1'b0;
    o_wb_m1_ack = 1'b0;
    o_wb_m0_rdt = '0;
    o_wb_m1_rdt = '0;
    if (own0) begin
      o_wb_adr    = i_wb_m0_adr;
      o_wb_dat    = i_wb_m0_dat;
      o_wb_sel    = i_wb_m0_sel;
      o_wb_we     = i_wb_m0_we;
      o_wb_m0_ack = i_wb_ack | to_hit;
      o_wb_m0_rdt = to_hit ? '1 : i_wb_rdt;
    end else if (own1) begin
      o_wb_adr    = i_wb_m1_adr;
      o_wb_dat    = i_wb_m1_dat;
      o_wb_sel    = i_wb_m1_sel;
      o_wb_we     = i_wb_m1_we;
      o_wb_m1_ack = i_wb_ack | to_hit;
      o_wb_m1_rdt = to_hit ? '1 : i_wb_rdt;
    end
  end

  // The slave strobe is withdrawn in the cycle the arbiter answers on the slave's behalf.
  assign o_wb_stb = owner_stb & ~to_hit;
  assign o_grant  = {own1, own0};

endmodule

// File: tb/tb_serving_wb_arbiter.sv
// Directed table-driven bench for serving_wb_arbiter plus hand-written multi-cycle sequences.
module tb_serving_wb_arbiter;

  localparam logic [31:0] M0_ADR = 32'h4000_0000;
  localparam logic [31:0] M0_DAT = 32'h1111_2222;
  localparam logic [3:0]  M0_SEL = 4'b1111;
  localparam logic        M0_WE  = 1'b0;
  localparam logic [31:0] M1_ADR = 32'h8000_0010;
  localparam logic [31:0] M1_DAT = 32'hCAFE_F00D;
  localparam logic [3:0]  M1_SEL = 4'b0011;
  localparam logic        M1_WE  = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m0_stb = 1'b0, m1_stb = 1'b0, s_ack = 1'b0;
  logic [31:0] s_rdt = '0;

  logic [31:0] m0_rdt, m1_rdt, w_adr, w_dat;
  logic [3:0]  w_sel;
  logic        m0_ack, m1_ack, w_we, w_stb, tmo;
  logic [1:0]  grant;

  logic [31:0] fp_m0_rdt, fp_m1_rdt, fp_adr, fp_dat;
  logic [3:0]  fp_sel;
  logic        fp_m0_ack, fp_m1_ack, fp_we, fp_stb, fp_tmo;
  logic [1:0]  fp_grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serving_wb_arbiter #(.RR(1), .TIMEOUT(1023)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_m0_adr(M0_ADR), .i_wb_m0_dat(M0_DAT), .i_wb_m0_sel(M0_SEL), .i_wb_m0_we(M0_WE),
    .i_wb_m0_stb(m0_stb), .o_wb_m0_rdt(m0_rdt), .o_wb_m0_ack(m0_ack),
    .i_wb_m1_adr(M1_ADR), .i_wb_m1_dat(M1_DAT), .i_wb_m1_sel(M1_SEL), .i_wb_m1_we(M1_WE),
    .i_wb_m1_stb(m1_stb), .o_wb_m1_rdt(m1_rdt), .o_wb_m1_ack(m1_ack),
    .o_wb_adr(w_adr), .o_wb_dat(w_dat), .o_wb_sel(w_sel), .o_wb_we(w_we), .o_wb_stb(w_stb),
    .i_wb_rdt(s_rdt), .i_wb_ack(s_ack), .o_grant(grant), .o_timeout(tmo)
  );

  serving_wb_arbiter #(.RR(0), .TIMEOUT(1023)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_wb_m0_adr(M0_ADR), .i_wb_m0_dat(M0_DAT), .i_wb_m0_sel(M0_SEL), .i_wb_m0_we(M0_WE),
    .i_wb_m0_stb(m0_stb), .o_wb_m0_rdt(fp_m0_rdt), .o_wb_m0_ack(fp_m0_ack),
    .i_wb_m1_adr(M1_ADR), .i_wb_m1_dat(M1_DAT), .i_wb_m1_sel(M1_SEL), .i_wb_m1_we(M1_WE),
    .i_wb_m1_stb(m1_stb), .o_wb_m1_rdt(fp_m1_rdt), .o_wb_m1_ack(fp_m1_ack),
    .o_wb_adr(fp_adr), .o_wb_dat(fp_dat), .o_wb_sel(fp_sel), .o_wb_we(fp_we), .o_wb_stb(fp_stb),
    .i_wb_rdt(s_rdt), .i_wb_ack(s_ack), .o_grant(fp_grant), .o_timeout(fp_tmo)
  );

`ifdef ARB_TIMEOUT_EN
  logic [31:0] to_m0_rdt, to_m1_rdt, to_adr, to_dat;
  logic [3:0]  to_sel;
  logic        to_m0_ack, to_m1_ack, to_we, to_stb, to_tmo;
  logic [1:0]  to_grant;

  serving_wb_arbiter #(.RR(1), .TIMEOUT(8)) dut_to (
    .i_clk(clk), .i_rst(rst),
    .i_wb_m0_adr(M0_ADR), .i_wb_m0_dat(M0_DAT), .i_wb_m0_sel(M0_SEL), .i_wb_m0_we(M0_WE),
    .i_wb_m0_stb(m0_stb), .o_wb_m0_rdt(to_m0_rdt), .o_wb_m0_ack(to_m0_ack),
    .i_wb_m1_adr(M1_ADR), .i_wb_m1_dat(M1_DAT), .i_wb_m1_sel(M1_SEL), .i_wb_m1_we(M1_WE),
    .i_wb_m1_stb(m1_stb), .o_wb_m1_rdt(to_m1_rdt), .o_wb_m1_ack(to_m1_ack),
    .o_wb_adr(to_adr), .o_wb_dat(to_dat), .o_wb_sel(to_sel), .o_wb_we(to_we), .o_wb_stb(to_stb),
    .i_wb_rdt(s_rdt), .i_wb_ack(s_ack), .o_grant(to_grant), .o_timeout(to_tmo)
  );
`endif

  typedef struct {
    logic       s0, s1, ack;
    logic [1:0] grant;
    logic       ostb, a0, a1;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs are sampled 2 ns later.
  task automatic cyc(input logic s0, input logic s1, input logic ack, input logic [31:0] rdt);
    @(negedge clk);
    m0_stb = s0;
    m1_stb = s1;
    s_ack  = ack;
    s_rdt  = rdt;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    s_ack  = 1'b0;
    rst    = 1'b1;
  endtask

  initial begin
    logic [31:0] rdt;
    logic [31:0] e_adr, e_dat, e_r0, e_r1;
    logic [3:0]  e_sel;
    logic        e_we;

    //          s0 s1 ack grant  stb a0 a1
    vecs[0]  = '{1, 1, 0, 2'b00, 0, 0, 0};
    vecs[1]  = '{1, 1, 1, 2'b01, 1, 1, 0};
    vecs[2]  = '{1, 1, 1, 2'b00, 0, 0, 0};
    vecs[3]  = '{1, 1, 1, 2'b10, 1, 0, 1};
    vecs[4]  = '{1, 1, 0, 2'b00, 0, 0, 0};
    vecs[5]  = '{1, 1, 1, 2'b01, 1, 1, 0};
    vecs[6]  = '{1, 1, 0, 2'b00, 0, 0, 0};
    vecs[7]  = '{1, 1, 1, 2'b10, 1, 0, 1};
    vecs[8]  = '{1, 0, 0, 2'b00, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 2'b01, 1, 0, 0};
    vecs[10] = '{1, 0, 1, 2'b01, 1, 1, 0};
    vecs[11] = '{0, 1, 0, 2'b00, 0, 0, 0};
    vecs[12] = '{0, 1, 0, 2'b10, 1, 0, 0};
    vecs[13] = '{0, 1, 1, 2'b10, 1, 0, 1};
    vecs[14] = '{1, 1, 0, 2'b00, 0, 0, 0};
    vecs[15] = '{0, 1, 0, 2'b01, 0, 0, 0};
    vecs[16] = '{0, 1, 1, 2'b00, 0, 0, 0};
    vecs[17] = '{0, 1, 0, 2'b10, 1, 0, 0};
    vecs[18] = '{0, 1, 1, 2'b10, 1, 0, 1};
    vecs[19] = '{0, 0, 0, 2'b00, 0, 0, 0};

    // Reset with both masters requesting and a stray slave ack.
    rst = 1'b0; m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b1; s_rdt = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #2;
    chk("reset grant",   32'(grant),  32'h0);
    chk("reset stb",     32'(w_stb),  32'h0);
    chk("reset m0_ack",  32'(m0_ack), 32'h0);
    chk("reset m1_ack",  32'(m1_ack), 32'h0);
    chk("reset timeout", 32'(tmo),    32'h0);
    @(negedge clk);
    m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      rdt = 32'h1234_5678 + 32'(i);
      cyc(vecs[i].s0, vecs[i].s1, vecs[i].ack, rdt);
      e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_r0 = '0; e_r1 = '0;
      if (vecs[i].grant == 2'b01) begin
        e_adr = M0_ADR; e_dat = M0_DAT; e_sel = M0_SEL; e_we = M0_WE; e_r0 = rdt;
      end else if (vecs[i].grant == 2'b10) begin
        e_adr = M1_ADR; e_dat = M1_DAT; e_sel = M1_SEL; e_we = M1_WE; e_r1 = rdt;
      end
      chk($sformatf("v%0d grant", i),  32'(grant),  32'(vecs[i].grant));
      chk($sformatf("v%0d stb", i),    32'(w_stb),  32'(vecs[i].ostb));
      chk($sformatf("v%0d m0_ack", i), 32'(m0_ack), 32'(vecs[i].a0));
      chk($sformatf("v%0d m1_ack", i), 32'(m1_ack), 32'(vecs[i].a1));
      chk($sformatf("v%0d m0_rdt", i), m0_rdt, e_r0);
      chk($sformatf("v%0d m1_rdt", i), m1_rdt, e_r1);
      chk($sformatf("v%0d adr", i),    w_adr, e_adr);
      chk($sformatf("v%0d dat", i),    w_dat, e_dat);
      chk($sformatf("v%0d sel", i),    32'(w_sel), 32'(e_sel));
      chk($sformatf("v%0d we", i),     32'(w_we),  32'(e_we));
    end

    // Fixed priority: m0 wins every contention.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      chk($sformatf("fp t%0d idle grant", t), 32'(fp_grant), 32'h0);
      cyc(1'b1, 1'b1, 1'b1, 32'hA5A5_0000 + 32'(t));
      chk($sformatf("fp t%0d grant", t),  32'(fp_grant),  32'h1);
      chk($sformatf("fp t%0d m0_ack", t), 32'(fp_m0_ack), 32'h1);
      chk($sformatf("fp t%0d m1_ack", t), 32'(fp_m1_ack), 32'h0);
    end

    // Reset asserted while m1 owns the bus.
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("mid grant before", 32'(grant), 32'h2);
    cyc(1'b0, 1'b1, 1'b1, 32'h5555_AAAA);
    chk("mid m1_ack before", 32'(m1_ack), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid reset stb",    32'(w_stb),  32'h0);
    chk("mid reset m1_ack", 32'(m1_ack), 32'h0);
    chk("mid reset m0_ack", 32'(m0_ack), 32'h0);
    chk("mid reset grant",  32'(grant),  32'h0);
    @(negedge clk);
    rst = 1'b1; m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b0;
    #2;
    chk("post reset idle", 32'(grant), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("post reset grant m0", 32'(grant), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("to wait%0d m0_ack", k), 32'(to_m0_ack), 32'h0);
      chk($sformatf("to wait%0d stb", k),    32'(to_stb),    32'h1);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("to fire m0_ack", 32'(to_m0_ack), 32'h1);
    chk("to fire m0_rdt", to_m0_rdt, 32'hFFFF_FFFF);
    chk("to fire stb",    32'(to_stb),    32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("to after grant", 32'(to_grant), 32'h0);
    chk("to flag set",    32'(to_tmo),   32'h1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("to flag sticky", 32'(to_tmo),   32'h1);
    do_reset();
    #2;
    chk("to flag cleared", 32'(to_tmo), 32'h0);
`else
    chk("timeout tied low", 32'(tmo), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serving_wb_arbiter.md
SERVING_WB_ARBITER -- requirements
Module: serving_wb_arbiter

Interface
REQ-001 SHALL have parameter RR, default 1; 1 = round-robin arbitration, 0 = fixed priority with m0 highest.
REQ-002 SHALL have parameter TIMEOUT, default 1023; cycles to wait for slave ack before abort; meaningful only with ARB_TIMEOUT_EN.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports i_wb_m0_adr and i_wb_m0_dat, input, 32 each, master 0 address and write data.
REQ-006 SHALL have ports i_wb_m0_sel (input, 4), i_wb_m0_we (input, 1) and i_wb_m0_stb (input, 1), master 0 byte select, write enable and request.
REQ-007 SHALL have ports o_wb_m0_rdt (output, 32) and o_wb_m0_ack (output, 1), master 0 read data and acknowledge.
REQ-008 SHALL have an identical port set for master 1, prefixed i_wb_m1_ / o_wb_m1_.
REQ-009 SHALL have ports o_wb_adr (output, 32), o_wb_dat (output, 32), o_wb_sel (output, 4), o_wb_we (output, 1) and o_wb_stb (output, 1), the shared slave bus.
REQ-010 SHALL have ports i_wb_rdt (input, 32) and i_wb_ack (input, 1), slave read data and acknowledge.
REQ-011 SHALL have port o_grant, output, 2, one-hot current owner; 00 when idle.
REQ-012 SHALL have port o_timeout, output, 1, sticky flag set when a slave timeout has occurred.

Function
REQ-013 SHALL implement a state machine with states IDLE, OWN0 and OWN1.
REQ-014 From IDLE, with one master's stb high, SHALL enter that master's OWN state on the next edge.
REQ-015 From IDLE, with both stb high: RR=1 SHALL grant the master not granted last (m0 first after reset); RR=0 SHALL always grant m0.
REQ-016 In OWNx, o_wb_stb SHALL equal i_wb_mx_stb, and adr/dat/sel/we SHALL mux from master x; in IDLE, o_wb_stb SHALL be 0 and the other slave outputs 0.
REQ-017 Minimum latency SHALL be 1 cycle from master stb to o_wb_stb.
REQ-018 In OWNx, o_wb_mx_ack SHALL equal i_wb_ack in the same cycle, and o_wb_mx_rdt SHALL equal i_wb_rdt; the non-owner's ack SHALL be 0 and its rdt 0.
REQ-019 On i_wb_ack in OWNx, the FSM SHALL return to IDLE on the next edge and record x as last granted; there SHALL be no back-to-back grant without passing through IDLE.
REQ-020 If the owner drops stb before ack (abort), the FSM SHALL return to IDLE on the next edge.
REQ-021 i_wb_ack in IDLE SHALL be ignored, with no master ack produced.
REQ-022 A non-owner's request SHALL be held pending, with no ack, until granted.

Reset
REQ-023 While i_rst is low, the FSM SHALL be IDLE, last granted SHALL be m1 (so m0 wins first), the timeout counter and o_timeout SHALL be 0, and all acks, o_wb_stb and o_grant SHALL be 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no ack issued.

Configuration
REQ-025 With macro ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to OWNx and increment each OWNx cycle without ack; on reaching TIMEOUT, the arbiter SHALL drive o_wb_mx_ack=1 with o_wb_mx_rdt=32'hFFFF_FFFF for one cycle, drive o_wb_stb=0 in that cycle, set o_timeout, and go to IDLE.
REQ-026 Without ARB_TIMEOUT_EN, the arbiter SHALL wait indefinitely for ack, o_timeout SHALL be tied 0, and no counter SHALL be instantiated.

Verification
REQ-027 Single read: m0 stb, adr=0x4000_0000; slave acks 2 cycles later with rdt=0x1234_5678 -> o_wb_stb 1 cycle after m0 stb, o_wb_m0_ack same cycle as i_wb_ack, rdt=0x1234_5678, o_grant=01 then 00.
REQ-028 Contention RR=1: m0 and m1 stb together, repeated 4 transactions -> grants m0,m1,m0,m1; with RR=0 -> all m0 while m0 requests.
REQ-029 Write pass-through: m1 we=1, dat=0xCAFEF00D, sel=0011 -> slave sees identical dat/sel/we; m0 ack stays 0.
REQ-030 Abort: m0 drops stb while granted, then slave acks -> no master ack, FSM IDLE, pending m1 granted next.
REQ-031 Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): slave never acks -> m0 ack after 8 cycles with rdt=0xFFFF_FFFF, o_timeout=1 until reset.
REQ-032 Reset mid-transaction: assert i_rst low while in OWN1 -> o_wb_stb, acks and o_grant 0 immediately; after release, a simultaneous request grants m0.
